// File: rtl/imem_responder_pkg.sv
// Shared types and constants for the instruction-memory responder.
// Holds the FSM encoding, the substituted NOP word and the latency bounds.
package imem_responder_pkg;

   typedef enum logic [1:0] {
      IMEM_IDLE = 2'd0,
      IMEM_WAIT = 2'd1,
      IMEM_RESP = 2'd2
   } imem_state_t;

   // addi x0,x0,0 -- returned in place of data for a bad fetch address
   localparam logic [31:0] RV_NOP = 32'h0000_0013;

   localparam int MIN_LATENCY = 1;
   localparam int MAX_LATENCY = 15;

   // Byte span covered by the array; offsets at or above this are out of range.
   function automatic logic [63:0] byte_span(input int depth_words);
      return 64'(depth_words) * 64'd4;
   endfunction

endpackage

// File: rtl/imem_responder_array.sv
// Word storage for the responder: one synchronous read port, one write port.
// A read and a write to the same index on one edge returns the old word.
module imem_array #(
   parameter int DEPTH_WORDS = 4096,
   parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
   input  logic              clk,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [31:0]       rd_data,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [31:0]       wr_data
);

   logic [31:0] mem [DEPTH_WORDS];

   // Both ports use non-blocking updates, so a same-edge read sees the old word.
   always_ff @(posedge clk) begin
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

endmodule

// File: rtl/imem_responder.sv
// Fixed-latency instruction-memory responder for the fetch interface.
// Valid/ready: a request is taken on a rising edge with inst_ena=1 and req_ready=1; inst_valid pulses once per taken request.
module imem_responder
   import imem_responder_pkg::*;
#(
   parameter int          DEPTH_WORDS = 4096,
   parameter int          LATENCY     = 2,
   parameter logic [63:0] BASE_ADDR   = 64'h0,
   parameter int          ADDR_W      = $clog2(DEPTH_WORDS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [63:0]       inst_addr,
   input  logic              inst_ena,
   output logic              req_ready,
   output logic [31:0]       inst,
   output logic              inst_valid,
   output logic              inst_fault,
   output logic              busy,
   input  logic              load_ena,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [31:0]       load_data,
   output imem_state_t       fsm_state
);

   localparam logic [63:0] SPAN   = byte_span(DEPTH_WORDS);
   localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

   generate
      if (LATENCY < MIN_LATENCY || LATENCY > MAX_LATENCY) begin : g_bad_latency
         $error("imem_responder: LATENCY must be in 1..15");
      end
   endgenerate

   imem_state_t state;
   imem_state_t state_nxt;
   logic [3:0]  cnt;
   logic [3:0]  cnt_nxt;

   logic [63:0] off;
   logic        bad;
   logic        accept;
   logic [31:0] rd_word;
   logic        fault_p;
   logic [31:0] resp_word;
   logic [31:0] inst_q;
   logic        fault_q;

   assign off    = inst_addr - BASE_ADDR;
   assign bad    = (inst_addr[1:0] != 2'b00) || (off >= SPAN);
   assign accept = inst_ena && req_ready;

   imem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .ADDR_W      (ADDR_W)
   ) u_array (
      .clk     (clk),
      .rd_en   (accept && !bad),
      .rd_addr (off[ADDR_W+1:2]),
      .rd_data (rd_word),
      .wr_en   (load_ena),
      .wr_addr (load_addr),
      .wr_data (load_data)
   );

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      unique case (state)
         IMEM_IDLE, IMEM_RESP: begin
            if (accept) begin
               if (LATENCY == 1) begin
                  state_nxt = IMEM_RESP;
               end else begin
                  state_nxt = IMEM_WAIT;
                  cnt_nxt   = LAT_M1;
               end
            end else begin
               state_nxt = IMEM_IDLE;
            end
         end
         IMEM_WAIT: begin
            if (cnt == 4'd1) begin
               state_nxt = IMEM_RESP;
               cnt_nxt   = 4'd0;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         default: begin
            state_nxt = IMEM_IDLE;
            cnt_nxt   = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IMEM_IDLE;
         cnt     <= 4'd0;
         fault_p <= 1'b0;
         inst_q  <= 32'h0;
         fault_q <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (accept) begin
            fault_p <= bad;
         end
         // Latch the presented response so it holds once inst_valid drops.
         if (inst_valid) begin
            inst_q  <= resp_word;
            fault_q <= fault_p;
         end
      end
   end

   // The pipeline register drives the output only in RESP; otherwise the held copy does.
   assign resp_word  = fault_p ? RV_NOP : rd_word;
   assign inst_valid = (state == IMEM_RESP);
   assign req_ready  = (state != IMEM_WAIT);
   assign busy       = (state != IMEM_IDLE);
   assign inst       = inst_valid ? resp_word : inst_q;
   assign inst_fault = inst_valid ? fault_p : fault_q;
   assign fsm_state  = state;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: three builds (LATENCY 2, LATENCY 1, LATENCY 3 at BASE 0x1000)
// checked every cycle against a request/response model, plus directed vectors and corner sequences.
module tb_imem_responder;
   import imem_responder_pkg::*;

   localparam int N  = 3;
   localparam int AW = 12;

   typedef struct {
      int          k;
      logic [63:0] addr;
      logic [31:0] word;
      logic        fault;
   } vec_t;

   logic              clk;
   logic              rst;
   logic [63:0]       addr_v  [N];
   logic              ena_v   [N];
   logic              ready_v [N];
   logic [31:0]       inst_v  [N];
   logic              valid_v [N];
   logic              fault_v [N];
   logic              busy_v  [N];
   imem_state_t       st_v    [N];
   logic              load_ena;
   logic [AW-1:0]     load_addr;
   logic [31:0]       load_data;

   int          checks;
   int          failures;
   int          cyc;
   bit          pend       [N];
   int          pend_cyc   [N];
   logic [31:0] pend_word  [N];
   bit          pend_fault [N];
   logic [31:0] last_word  [N];
   bit          last_fault [N];
   logic [31:0] mem_m      [4096];
   vec_t        vecs       [12];

   imem_responder #(.DEPTH_WORDS(4096), .LATENCY(2), .BASE_ADDR(64'h0)) u0 (
      .clk(clk), .rst(rst), .inst_addr(addr_v[0]), .inst_ena(ena_v[0]), .req_ready(ready_v[0]),
      .inst(inst_v[0]), .inst_valid(valid_v[0]), .inst_fault(fault_v[0]), .busy(busy_v[0]),
      .load_ena(load_ena), .load_addr(load_addr), .load_data(load_data), .fsm_state(st_v[0]));

   imem_responder #(.DEPTH_WORDS(4096), .LATENCY(1), .BASE_ADDR(64'h0)) u1 (
      .clk(clk), .rst(rst), .inst_addr(addr_v[1]), .inst_ena(ena_v[1]), .req_ready(ready_v[1]),
      .inst(inst_v[1]), .inst_valid(valid_v[1]), .inst_fault(fault_v[1]), .busy(busy_v[1]),
      .load_ena(load_ena), .load_addr(load_addr), .load_data(load_data), .fsm_state(st_v[1]));

   imem_responder #(.DEPTH_WORDS(4096), .LATENCY(3), .BASE_ADDR(64'h1000)) u2 (
      .clk(clk), .rst(rst), .inst_addr(addr_v[2]), .inst_ena(ena_v[2]), .req_ready(ready_v[2]),
      .inst(inst_v[2]), .inst_valid(valid_v[2]), .inst_fault(fault_v[2]), .busy(busy_v[2]),
      .load_ena(load_ena), .load_addr(load_addr), .load_data(load_data), .fsm_state(st_v[2]));

   // clock / watchdog
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      failures++;
      $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

   // reference model
   function automatic int lat_of(input int k);
      case (k)
         0:       return 2;
         1:       return 1;
         default: return 3;
      endcase
   endfunction

   function automatic logic [63:0] base_of(input int k);
      return (k == 2) ? 64'h1000 : 64'h0;
   endfunction

   function automatic bit addr_is_bad(input int k, input logic [63:0] addr);
      logic [63:0] o;
      o = addr - base_of(k);
      return ((addr % 64'd4) != 64'd0) || (o >= 64'd16384);
   endfunction

   function automatic bit ready_exp(input int k);
      return !pend[k] || (cyc == pend_cyc[k]);
   endfunction

   task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s u%0d cyc=%0d got=%h want=%h", name, k, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < N; k++) begin
         pend[k]       = 1'b0;
         last_word[k]  = 32'h0;
         last_fault[k] = 1'b0;
      end
   endtask

   // Advance one rising edge and update the model from the inputs that edge sees.
   task automatic step();
      bit          acc [N];
      logic [31:0] w   [N];
      bit          f   [N];
      for (int k = 0; k < N; k++) begin
         acc[k] = rst && ena_v[k] && ready_exp(k);
         f[k]   = addr_is_bad(k, addr_v[k]);
         w[k]   = f[k] ? 32'h0000_0013 : mem_m[int'((addr_v[k] - base_of(k)) / 64'd4)];
      end
      @(posedge clk);
      for (int k = 0; k < N; k++) begin
         if (pend[k] && cyc == pend_cyc[k]) pend[k] = 1'b0;
      end
      cyc++;
      for (int k = 0; k < N; k++) begin
         if (acc[k]) begin
            pend[k]       = 1'b1;
            pend_cyc[k]   = cyc + lat_of(k) - 1;
            pend_word[k]  = w[k];
            pend_fault[k] = f[k];
         end
      end
      if (load_ena) mem_m[load_addr] = load_data;
   endtask

   task automatic check_outputs();
      bit v;
      for (int k = 0; k < N; k++) begin
         v = pend[k] && (cyc == pend_cyc[k]);
         if (v) begin
            last_word[k]  = pend_word[k];
            last_fault[k] = pend_fault[k];
         end
         chk("inst_valid", k, 32'(valid_v[k]), 32'(v));
         chk("req_ready", k, 32'(ready_v[k]), 32'(ready_exp(k)));
         chk("busy", k, 32'(busy_v[k]), 32'(pend[k]));
         chk("state_idle", k, 32'(st_v[k] == IMEM_IDLE), 32'(!pend[k]));
         chk("inst", k, inst_v[k], last_word[k]);
         chk("inst_fault", k, 32'(fault_v[k]), 32'(last_fault[k]));
      end
   endtask

   task automatic cycle();
      step();
      @(negedge clk);
      check_outputs();
   endtask

   // driver tasks
   task automatic load_word(input int idx, input logic [31:0] data);
      load_ena  = 1'b1;
      load_addr = AW'(idx);
      load_data = data;
      cycle();
      load_ena  = 1'b0;
   endtask

   task automatic fetch(input int k, input logic [63:0] addr,
                        output logic [31:0] word, output logic fault, output int lat, output bit ok);
      addr_v[k] = addr;
      ena_v[k]  = 1'b1;
      cycle();
      ena_v[k]  = 1'b0;
      ok = 1'b0; word = 32'h0; fault = 1'b0; lat = 0;
      for (int i = 0; i < 20; i++) begin
         if (valid_v[k]) begin
            ok = 1'b1; word = inst_v[k]; fault = fault_v[k]; lat = i + 1;
            break;
         end
         cycle();
      end
      if (!ok) chk("fetch_timeout", k, 32'(ok), 32'd1);
      cycle();
   endtask

   initial begin
      logic [31:0] w;
      logic        f;
      int          lat;
      bit          ok;
      int          vcyc [$];
      logic [31:0] vword [$];

      checks = 0; failures = 0; cyc = 0;
      load_ena = 1'b0; load_addr = '0; load_data = 32'h0;
      for (int k = 0; k < N; k++) begin
         addr_v[k] = 64'h0;
         ena_v[k]  = 1'b0;
      end

      // reset state
      rst = 1'b0;
      #1;
      model_reset();
      check_outputs();
      cycle();
      cycle();
      rst = 1'b1;
      cycle();

      load_word(0, 32'h0010_0093);
      load_word(1, 32'h0020_0113);
      load_word(2, 32'h0030_8193);
      load_word(3, 32'h0040_8213);
      load_word(4095, 32'hCAFE_F00D);

      // directed vectors
      vecs[0]  = '{0, 64'h8,                  32'h0030_8193, 1'b0};
      vecs[1]  = '{0, 64'h6,                  32'h0000_0013, 1'b1};
      vecs[2]  = '{0, 64'h4000,               32'h0000_0013, 1'b1};
      vecs[3]  = '{0, 64'h3FFC,               32'hCAFE_F00D, 1'b0};
      vecs[4]  = '{0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0000_0013, 1'b1};
      vecs[5]  = '{1, 64'h4,                  32'h0020_0113, 1'b0};
      vecs[6]  = '{1, 64'h2,                  32'h0000_0013, 1'b1};
      vecs[7]  = '{2, 64'h0FFC,               32'h0000_0013, 1'b1};
      vecs[8]  = '{2, 64'h100C,               32'h0040_8213, 1'b0};
      vecs[9]  = '{2, 64'h1003,               32'h0000_0013, 1'b1};
      vecs[10] = '{2, 64'h5000,               32'h0000_0013, 1'b1};
      vecs[11] = '{2, 64'h4FFC,               32'hCAFE_F00D, 1'b0};
      for (int i = 0; i < 12; i++) begin
         fetch(vecs[i].k, vecs[i].addr, w, f, lat, ok);
         if (ok) begin
            chk("vec_word", vecs[i].k, w, vecs[i].word);
            chk("vec_fault", vecs[i].k, 32'(f), 32'(vecs[i].fault));
            chk("vec_latency", vecs[i].k, 32'(lat), 32'(lat_of(vecs[i].k)));
         end
      end

      // back-to-back on LATENCY=2: requests during WAIT are dropped
      addr_v[0] = 64'h0;
      ena_v[0]  = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cycle();
         addr_v[0] = 64'h4;
         if (valid_v[0]) begin
            vcyc.push_back(cyc);
            vword.push_back(inst_v[0]);
         end
      end
      ena_v[0] = 1'b0;
      cycle(); cycle(); cycle();
      chk("b2b_count", 0, 32'(vcyc.size()), 32'd3);
      if (vcyc.size() >= 2) begin
         chk("b2b_word0", 0, vword[0], 32'h0010_0093);
         chk("b2b_word1", 0, vword[1], 32'h0020_0113);
         chk("b2b_spacing", 0, 32'(vcyc[1] - vcyc[0]), 32'd2);
      end

      // LATENCY=1 streaming
      ena_v[1] = 1'b1;
      addr_v[1] = 64'h0; cycle();
      chk("l1_word0", 1, inst_v[1], 32'h0010_0093);
      chk("l1_ready0", 1, 32'(ready_v[1]), 32'd1);
      addr_v[1] = 64'h4; cycle();
      chk("l1_word1", 1, inst_v[1], 32'h0020_0113);
      chk("l1_valid1", 1, 32'(valid_v[1]), 32'd1);
      addr_v[1] = 64'h8; cycle();
      chk("l1_word2", 1, inst_v[1], 32'h0030_8193);
      chk("l1_valid2", 1, 32'(valid_v[1]), 32'd1);
      ena_v[1] = 1'b0;
      cycle(); cycle();

      // same-edge load and accept returns old word; loads while in flight do not disturb it
      load_ena = 1'b1; load_addr = AW'(2); load_data = 32'hDEAD_BEEF;
      fetch(0, 64'h8, w, f, lat, ok);
      load_ena = 1'b0;
      chk("rbw_old", 0, w, 32'h0030_8193);
      fetch(0, 64'h8, w, f, lat, ok);
      chk("rbw_new", 0, w, 32'hDEAD_BEEF);

      // reset during WAIT aborts the response
      addr_v[0] = 64'h0;
      ena_v[0]  = 1'b1;
      cycle();
      ena_v[0]  = 1'b0;
      chk("abort_busy_before", 0, 32'(busy_v[0]), 32'd1);
      rst = 1'b0;
      #1;
      model_reset();
      check_outputs();
      cycle();
      rst = 1'b1;
      for (int i = 0; i < 4; i++) cycle();
      fetch(0, 64'h0, w, f, lat, ok);
      chk("after_reset_word", 0, w, 32'h0010_0093);

      // randomized traffic with background loads
      for (int i = 0; i < 64; i++) load_word(i, $urandom);
      for (int i = 0; i < 400; i++) begin
         for (int k = 0; k < N; k++) begin
            int r;
            ena_v[k] = ($urandom_range(0, 2) != 0);
            r = $urandom_range(0, 9);
            case (r)
               6:       addr_v[k] = base_of(k) + 64'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
               7:       addr_v[k] = base_of(k) + 64'h4000 + 64'($urandom_range(0, 255) * 4);
               8:       addr_v[k] = base_of(k) - 64'($urandom_range(1, 4) * 4);
               9:       addr_v[k] = base_of(k) + 64'h3FFC;
               default: addr_v[k] = base_of(k) + 64'($urandom_range(0, 63) * 4);
            endcase
         end
         load_ena  = ($urandom_range(0, 3) == 0);
         load_addr = AW'($urandom_range(0, 63));
         load_data = $urandom;
         cycle();
      end
      for (int k = 0; k < N; k++) ena_v[k] = 1'b0;
      load_ena = 1'b0;
      for (int i = 0; i < 5; i++) cycle();

      // report
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder on the fetch interface: the slave end of the fetch request that `if_stage` issues as `inst_addr` / `inst_ena`.
- Accepts one 64-bit fetch address per request and returns the 32-bit word after a fixed, parameterised latency, with a valid strobe and a fault flag.
- Has a side load port so benches and boot logic can preload programs.
- Sits beside `rvcpu` at the SoC/testbench level. It replaces the ideal zero-latency `inst` tie-off.

Parameters:
- DEPTH_WORDS, 4096, number of 32-bit words stored.
- LATENCY, 2, cycles from the accepting edge to `inst_valid`. Legal range is 1..15; elaboration error outside it.
- BASE_ADDR, 64'h0, byte address of word 0.
- ADDR_W, $clog2(DEPTH_WORDS), word-index width (derived).

Ports:
- clk  input  1  single clock, all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- inst_addr  input  64  fetch byte address from the fetch stage.
- inst_ena  input  1  fetch request strobe.
- req_ready  output  1  responder can accept a request this cycle.
- inst  output  32  returned instruction word.
- inst_valid  output  1  one-cycle strobe: `inst` / `inst_fault` are valid.
- inst_fault  output  1  the returned word is a substituted NOP because of a bad address.
- busy  output  1  a request is in flight (state != IDLE).
- load_ena  input  1  preload write strobe.
- load_addr  input  ADDR_W  preload word index.
- load_data  input  32  preload word.

Behaviour:
- Reset (rst=0, async), applied immediately:
  - State → IDLE; latency counter → 0.
  - Outputs: `inst`=0, `inst_valid`=0, `inst_fault`=0, `req_ready`=1, `busy`=0.
  - Memory contents are not reset.
  - Reset mid-flight aborts the request; no `inst_valid` is ever produced for it.
- Accept rule: a request is accepted on the rising edge where `inst_ena`=1 and `req_ready`=1. If `inst_ena`=1 while `req_ready`=0, the request is ignored, not queued. The requester must hold or retry.
- Address check, evaluated at the accepting edge, with `off` = `inst_addr` − BASE_ADDR (64-bit unsigned, wrap-around allowed):
  - Misaligned (`inst_addr[1:0]` != 0) → fault.
  - Out of range (`off` ≥ DEPTH_WORDS*4, which includes `inst_addr` < BASE_ADDR via wrap) → fault.
  - Fault response: `inst`=32'h0000_0013 (addi x0,x0,0) and `inst_fault`=1.
  - Otherwise: `inst` = mem[`off`[ADDR_W+1:2]] and `inst_fault`=0.
- Read timing:
  - The word is read synchronously at the accepting edge into a pipeline register.
  - Later loads to the same index do not change an in-flight response.
  - Simultaneous load and accept at the same index returns the old data (read-before-write).
- Load port:
  - Writes mem[`load_addr`] ← `load_data` on any edge where `load_ena`=1, independent of fetch state.
  - Never stalls.
- State machine:
  - IDLE: `req_ready`=1. On accept with LATENCY=1 → RESP; on accept with LATENCY>1 → WAIT with counter=LATENCY−1.
  - WAIT: `req_ready`=0. Counter decrements each edge; on the edge where counter=1 → RESP.
  - RESP: `inst_valid`=1 for exactly this cycle and `req_ready`=1. On accept → WAIT or RESP (back-to-back); otherwise → IDLE.
- Latency: `inst_valid` is high in cycle LATENCY after the accepting edge, where cycle 1 is the cycle immediately following that edge.
- Throughput: one response per LATENCY cycles.
- Hold: `inst` and `inst_fault` hold their last response value after `inst_valid` drops, until the next response.
- `busy` = (state != IDLE).

Decomposition:
- Add to `sys_defs.svh`:
  - typedef enum logic [1:0] `IMEM_STATE` {IMEM_IDLE, IMEM_WAIT, IMEM_RESP}.
  - `define RV_NOP 32'h0000_0013.
- Sub-module `imem_array`: DEPTH_WORDS×32 storage with one synchronous read port (en, addr, data) and one write port, read-before-write.
- FSM, counter, address check and output registers stay in `imem_responder`.

Test Plan:
- Reset then preload mem[0..3] = 0x00100093, 0x00200113, 0x00308193, 0x00408213; LATENCY=2; request `inst_addr`=0x8 → `inst_valid` in cycle 2 with `inst`=0x00308193, `inst_fault`=0; `req_ready`=0 in cycle 1.
- Back-to-back: request addr 0x0, then hold `inst_ena`=1 with addr 0x4 → responses 0x00100093 and 0x00200113 spaced exactly 2 cycles apart; the request presented during WAIT is ignored.
- `inst_addr`=0x6 → `inst`=0x00000013, `inst_fault`=1. With DEPTH_WORDS=4096, `inst_addr`=0x4000 → same NOP response with fault; with BASE_ADDR=0x1000, `inst_addr`=0x0FFC → fault.
- Same edge: `load_ena`=1, `load_addr`=2, `load_data`=0xDEADBEEF, and accept at addr 0x8 → returns 0x00308193. A second fetch of 0x8 → returns 0xDEADBEEF.
- Assert rst=0 in cycle 1 of WAIT → `inst_valid` never rises, `busy`=0 and `req_ready`=1 immediately. After release, a request for 0x0 completes normally and the memory still holds 0x00100093.
- LATENCY=1 build: continuous requests 0x0, 0x4, 0x8 → `inst_valid` high every cycle with the correct words and `req_ready` constantly 1.
